// File: rtl/product_bcd_converter_v.sv
// Sequential double-dabble converter: turns the 8-bit multiplier product into three BCD digits,
// one bit per clock, framed by a start/busy/done handshake.
module product_bcd_converter_v (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [3:0] i_fu0,
    input  logic [3:0] i_fu1,
    output logic       o_busy,
    output logic       o_done,
    output logic [3:0] o_bcd0,
    output logic [3:0] o_bcd1,
    output logic [3:0] o_bcd2
);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state;
    logic [7:0]  bin;
    logic [11:0] sc;
    logic [11:0] sc_adj;
    logic [11:0] sc_next;
    logic [3:0]  cnt;

    // Correct every digit that would overflow past 9 once doubled, then shift in the next bit.
    always_comb begin
        sc_adj = sc;
        for (int i = 0; i < 3; i++) begin
            if (sc[4*i +: 4] >= 4'd5) begin
                sc_adj[4*i +: 4] = sc[4*i +: 4] + 4'd3;
            end
        end
        sc_next = {sc_adj[10:0], bin[7]};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= IDLE;
            bin    <= 8'd0;
            sc     <= 12'd0;
            cnt    <= 4'd0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
            o_bcd0 <= 4'd0;
            o_bcd1 <= 4'd0;
            o_bcd2 <= 4'd0;
        end else begin
            o_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start) begin
                        bin    <= {i_fu1, i_fu0};
                        sc     <= 12'd0;
                        cnt    <= 4'd0;
                        o_busy <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sc  <= sc_next;
                    bin <= {bin[6:0], 1'b0};
                    cnt <= cnt + 4'd1;
                    // Final bit: publish the result directly so the outputs never show partial digits.
                    if (cnt == 4'd7) begin
                        o_bcd2 <= sc_next[11:8];
                        o_bcd1 <= sc_next[7:4];
                        o_bcd0 <= sc_next[3:0];
                        o_done <= 1'b1;
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
